// File: rtl/tick_div_pkg.sv
// Shared constants for the multi-channel tick divider.
package tick_div_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  localparam int PKG_DEFAULT_DIV = 125;

endpackage

// File: rtl/tick_div_channel.sv
// One divider channel: counter, active div/mode, shadow registers and
// registered tick / divided-clock outputs.
module tick_div_channel
  import tick_div_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = PKG_DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_div_i,
  input  logic             load_mode_i,
  output logic             tick_o,
  output logic             clk_out_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             mode_q, mode_d;
  logic             shadow_mode_q, shadow_mode_d;
  logic             pending_q, pending_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             terminal;
  logic             apply;

  assign terminal = en_i && (count_q == div_q - WIDTH'(1));
  // A disabled channel has no period to finish, so a pending write lands at once.
  assign apply    = pending_q && (terminal || !en_i);

  always_comb begin
    count_d       = count_q;
    div_d         = div_q;
    mode_d        = mode_q;
    shadow_d      = shadow_q;
    shadow_mode_d = shadow_mode_q;
    pending_d     = pending_q;
    tick_d        = 1'b0;
    clk_out_d     = 1'b0;

    // Apply reads the old shadow, so a write in the same cycle stays pending.
    if (apply) begin
      div_d     = shadow_q;
      mode_d    = shadow_mode_q;
      pending_d = 1'b0;
    end
    if (load_i) begin
      shadow_d      = load_div_i;
      shadow_mode_d = load_mode_i;
      pending_d     = 1'b1;
    end

    if (!en_i) begin
      count_d = '0;
    end else if (terminal) begin
      count_d = '0;
      tick_d  = 1'b1;
    end else begin
      count_d = count_q + WIDTH'(1);
    end

    if (en_i) begin
      if (mode_d == MODE_PULSE) clk_out_d = tick_d;
      else if (mode_q == MODE_PULSE) clk_out_d = 1'b0;
      else clk_out_d = clk_out_q ^ terminal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q       <= '0;
      div_q         <= WIDTH'(DEFAULT_DIV);
      shadow_q      <= WIDTH'(DEFAULT_DIV);
      mode_q        <= MODE_TOGGLE;
      shadow_mode_q <= MODE_TOGGLE;
      pending_q     <= 1'b0;
      tick_q        <= 1'b0;
      clk_out_q     <= 1'b0;
    end else begin
      count_q       <= count_d;
      div_q         <= div_d;
      shadow_q      <= shadow_d;
      mode_q        <= mode_d;
      shadow_mode_q <= shadow_mode_d;
      pending_q     <= pending_d;
      tick_q        <= tick_d;
      clk_out_q     <= clk_out_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;

endmodule

// File: rtl/tick_divider_multi.sv
// Multi-channel tick divider: validates config writes, returns ack/err and
// routes accepted writes to the addressed channel's shadow.
module tick_divider_multi
  import tick_div_pkg::*;
#(
  parameter  int WIDTH       = 16,
  parameter  int NUM_CH      = 2,
  parameter  int DEFAULT_DIV = PKG_DEFAULT_DIV,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              cfg_wr_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [WIDTH-1:0]  cfg_div_i,
  input  logic              cfg_mode_i,
  output logic              cfg_ack_o,
  output logic              cfg_err_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_out_o
);

  logic wr_ok;
  logic cfg_ack_q;
  logic cfg_err_q;

  assign wr_ok = cfg_wr_i && (int'(cfg_ch_i) < NUM_CH) && (cfg_div_i != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ack_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_ack_q <= wr_ok;
      cfg_err_q <= cfg_wr_i && !wr_ok;
    end
  end

  assign cfg_ack_o = cfg_ack_q;
  assign cfg_err_o = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_div_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .en_i       (en_i[g]),
      .load_i     (wr_ok && (cfg_ch_i == CH_W'(g))),
      .load_div_i (cfg_div_i),
      .load_mode_i(cfg_mode_i),
      .tick_o     (tick_o[g]),
      .clk_out_o  (clk_out_o[g])
    );
  end

endmodule
